// File: rtl/ex_stage_pkg.sv
// Shared definitions for the RV32I execute stage: datapath width, opcodes,
// funct7 selectors and the ALU operation encoding used between ex_stage and ex_alu.
// Ports: none (package only).
package ex_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_ZERO
    } alu_op_e;

endpackage

// File: rtl/ex_alu.sv
// Pure combinational ALU: applies the selected operation to operands a and b.
// Latency: zero (combinational). Backpressure: none, result follows inputs.
// Ports: op (operation select), a/b (operands), result.
module ex_alu
    import ex_stage_pkg::*;
(
    input  alu_op_e              op,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    output logic [XLEN-1:0]      result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_ZERO: result = '0;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU result, branch/jump decision and target, custom-op flag.
// Latency: primary outputs zero-cycle combinational; *_q copies one cycle later.
// Backpressure: none, the EX/MEM copy is captured on every rising clk edge.
// Ports: decoded opcode/funct3/funct7, rs1_val/rs2_val/imm/pc_in in;
//        alu_result/branch_taken/branch_target/custom_valid and their _q copies out.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  pc_in,
    output logic [XLEN-1:0]  alu_result,
    output logic             branch_taken,
    output logic [XLEN-1:0]  branch_target,
    output logic             custom_valid,
    output logic [XLEN-1:0]  alu_result_q,
    output logic             branch_taken_q,
    output logic [XLEN-1:0]  branch_target_q,
    output logic             custom_valid_q
);

    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_out;

    logic [XLEN-1:0] alu_result_d;
    logic            branch_taken_d;
    logic [XLEN-1:0] branch_target_d;
    logic            custom_valid_d;

    logic [XLEN-1:0] pc_rel_target;
    logic [XLEN-1:0] jalr_sum;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            cmp_ltu;

    // Operand muxing and operation select. Register-register and
    // register-immediate forms share one funct3 decode; only the B operand
    // and the SUB qualification differ.
    always_comb begin
        alu_op         = ALU_ZERO;
        alu_a          = rs1_val;
        alu_b          = imm;
        custom_valid_d = 1'b0;
        case (opcode)
            OP_IMM, OP: begin
                if (opcode == OP) alu_b = rs2_val;
                case (funct3)
                    3'b000: alu_op = (opcode == OP && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    // Shift type comes from funct7 only, never from imm[10].
                    3'b101: alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
                // M-extension/custom R-type is executed elsewhere; result forced to 0.
                if (opcode == OP && funct7 == F7_MULDIV) begin
                    alu_op         = ALU_ZERO;
                    custom_valid_d = 1'b1;
                end
            end
            LOAD, STORE: alu_op = ALU_ADD;
            LUI: begin
                alu_op = ALU_ADD;
                alu_a  = '0;
            end
            AUIPC: begin
                alu_op = ALU_ADD;
                alu_a  = pc_in;
            end
            JAL, JALR: begin
                // Link value pc+4.
                alu_op = ALU_ADD;
                alu_a  = pc_in;
                alu_b  = XLEN'(4);
            end
            default: alu_op = ALU_ZERO;
        endcase
    end

    ex_alu u_alu (
        .op     (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_out)
    );

    assign alu_result_d  = alu_out;
    assign pc_rel_target = pc_in + imm;
    assign jalr_sum      = rs1_val + imm;
    assign cmp_eq        = (rs1_val == rs2_val);
    assign cmp_lt        = ($signed(rs1_val) < $signed(rs2_val));
    assign cmp_ltu       = (rs1_val < rs2_val);

    always_comb begin
        branch_taken_d  = 1'b0;
        branch_target_d = pc_rel_target;
        case (opcode)
            BRANCH: begin
                case (funct3)
                    3'b000:  branch_taken_d = cmp_eq;
                    3'b001:  branch_taken_d = !cmp_eq;
                    3'b100:  branch_taken_d = cmp_lt;
                    3'b101:  branch_taken_d = !cmp_lt;
                    3'b110:  branch_taken_d = cmp_ltu;
                    3'b111:  branch_taken_d = !cmp_ltu;
                    default: branch_taken_d = 1'b0;
                endcase
            end
            JAL: branch_taken_d = 1'b1;
            JALR: begin
                branch_taken_d  = 1'b1;
                branch_target_d = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: branch_taken_d = 1'b0;
        endcase
    end

    assign alu_result    = alu_result_d;
    assign branch_taken  = branch_taken_d;
    assign branch_target = branch_target_d;
    assign custom_valid  = custom_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q    <= '0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            custom_valid_q  <= 1'b0;
        end else begin
            alu_result_q    <= alu_result_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            custom_valid_q  <= custom_valid_d;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized OP-IMM/OP
// vectors compared against a behavioural model written from the ISA rules.
// Ports: none (top-level bench).
module tb_ex_stage;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_val, rs2_val, imm, pc_in;
    logic [31:0] alu_result, branch_target, alu_result_q, branch_target_q;
    logic        branch_taken, custom_valid, branch_taken_q, custom_valid_q;

    int total = 0;
    int bad   = 0;

    ex_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7),
        .rs1_val         (rs1_val),
        .rs2_val         (rs2_val),
        .imm             (imm),
        .pc_in           (pc_in),
        .alu_result      (alu_result),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .custom_valid    (custom_valid),
        .alu_result_q    (alu_result_q),
        .branch_taken_q  (branch_taken_q),
        .branch_target_q (branch_target_q),
        .custom_valid_q  (custom_valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] pc);
        opcode  = op;
        funct3  = f3;
        funct7  = f7;
        rs1_val = a;
        rs2_val = b;
        imm     = im;
        pc_in   = pc;
        #1;
    endtask

    // Reference for OP-IMM / OP: returns {custom_valid, alu_result}.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] r2, input logic [31:0] im);
        logic [31:0] b;
        logic [31:0] res;
        int sh;
        bit is_r;
        is_r = (op == 7'b0110011);
        if (is_r && f7 == 7'b0000001) return {1'b1, 32'h0};
        b  = is_r ? r2 : im;
        sh = int'(b[4:0]);
        case (f3)
            3'd0: res = (is_r && f7 == 7'b0100000) ? a - b : a + b;
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: begin
                res = a >> sh;
                if (f7 == 7'b0100000 && a[31]) res = res | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: res = a | b;
            default: res = a & b;
        endcase
        return {1'b0, res};
    endfunction

    initial begin
        logic [32:0] exp;
        logic [6:0]  f7_pool [4];
        f7_pool[0] = 7'b0000000;
        f7_pool[1] = 7'b0100000;
        f7_pool[2] = 7'b0000001;
        f7_pool[3] = 7'b1010101;

        rst_n = 1'b0;
        drive(7'b0110011, 3'd0, 7'd0, 32'd7, 32'd4, 32'd0, 32'd0);
        @(negedge clk);
        check("rst_alu_q", alu_result_q, 32'd0);
        check("rst_tgt_q", branch_target_q, 32'd0);
        check("rst_taken_q", {31'd0, branch_taken_q}, 32'd0);
        check("rst_cv_q", {31'd0, custom_valid_q}, 32'd0);

        // Shifts
        drive(7'b0010011, 3'd5, 7'b0100000, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
        check("srai", alu_result, 32'hF800_0000);
        drive(7'b0010011, 3'd5, 7'b0000000, 32'h8000_0000, 32'd0, 32'd4, 32'd0);
        check("srli", alu_result, 32'h0800_0000);
        drive(7'b0010011, 3'd5, 7'b0000000, 32'h8000_0000, 32'd0, 32'h404, 32'd0);
        check("srli_imm10", alu_result, 32'h0800_0000);
        drive(7'b0110011, 3'd5, 7'b0100000, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
        check("sra", alu_result, 32'hF800_0000);
        drive(7'b0110011, 3'd5, 7'b0000000, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
        check("srl", alu_result, 32'h0800_0000);

        // Compares
        drive(7'b0110011, 3'd2, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        check("slt", alu_result, 32'd1);
        drive(7'b0110011, 3'd3, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        check("sltu", alu_result, 32'd0);
        drive(7'b0010011, 3'd2, 7'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0);
        check("slti", alu_result, 32'd1);

        // Branches: pc=0x100, imm=8
        drive(7'b1100011, 3'd0, 7'd0, 32'd5, 32'd5, 32'd8, 32'h100);
        check("beq_t", {31'd0, branch_taken}, 32'd1);
        check("beq_tgt", branch_target, 32'h108);
        drive(7'b1100011, 3'd1, 7'd0, 32'd5, 32'd6, 32'd8, 32'h100);
        check("bne_t", {31'd0, branch_taken}, 32'd1);
        drive(7'b1100011, 3'd4, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h100);
        check("blt_t", {31'd0, branch_taken}, 32'd1);
        drive(7'b1100011, 3'd5, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h100);
        check("bge_nt", {31'd0, branch_taken}, 32'd0);
        drive(7'b1100011, 3'd7, 7'd0, 32'd2, 32'd1, 32'd8, 32'h100);
        check("bgeu_t", {31'd0, branch_taken}, 32'd1);
        drive(7'b1100011, 3'd6, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd8, 32'h100);
        check("bltu_nt", {31'd0, branch_taken}, 32'd0);
        check("bltu_tgt", branch_target, 32'h108);
        drive(7'b1100011, 3'd2, 7'd0, 32'd5, 32'd5, 32'd8, 32'h100);
        check("b010_nt", {31'd0, branch_taken}, 32'd0);

        // Jumps
        drive(7'b1101111, 3'd0, 7'd0, 32'd0, 32'd0, 32'h10, 32'h100);
        check("jal_t", {31'd0, branch_taken}, 32'd1);
        check("jal_tgt", branch_target, 32'h110);
        check("jal_link", alu_result, 32'h104);
        drive(7'b1100111, 3'd0, 7'd0, 32'h1234, 32'd0, 32'd4, 32'h100);
        check("jalr_t", {31'd0, branch_taken}, 32'd1);
        check("jalr_tgt", branch_target, 32'h1238);
        drive(7'b1100111, 3'd0, 7'd0, 32'h1235, 32'd0, 32'd0, 32'h100);
        check("jalr_bit0", branch_target, 32'h1234);

        // Custom, ADD, AUIPC, LUI, LOAD, unknown
        drive(7'b0110011, 3'd0, 7'b0000001, 32'd7, 32'd4, 32'd0, 32'd0);
        check("mul_res", alu_result, 32'd0);
        check("mul_cv", {31'd0, custom_valid}, 32'd1);
        drive(7'b0110011, 3'd0, 7'd0, 32'd7, 32'd4, 32'd0, 32'd0);
        check("add_res", alu_result, 32'd11);
        check("add_cv", {31'd0, custom_valid}, 32'd0);
        drive(7'b0110011, 3'd0, 7'b0100000, 32'd4, 32'd7, 32'd0, 32'd0);
        check("sub_wrap", alu_result, 32'hFFFF_FFFD);
        drive(7'b0010111, 3'd0, 7'd0, 32'd0, 32'd0, 32'h1000, 32'h100);
        check("auipc", alu_result, 32'h1100);
        drive(7'b0110111, 3'd0, 7'd0, 32'h55, 32'd0, 32'hABCD_E000, 32'h100);
        check("lui", alu_result, 32'hABCD_E000);
        drive(7'b0000011, 3'd2, 7'd0, 32'h2000, 32'd0, 32'hFFFF_FFFC, 32'h100);
        check("load_addr", alu_result, 32'h1FFC);
        drive(7'b1111111, 3'd0, 7'd0, 32'h2000, 32'd3, 32'h8, 32'h100);
        check("unk_res", alu_result, 32'd0);
        check("unk_taken", {31'd0, branch_taken}, 32'd0);
        check("unk_tgt", branch_target, 32'h108);

        // Registered copies and asynchronous reset
        @(negedge clk);
        rst_n = 1'b1;
        drive(7'b1101111, 3'd0, 7'd0, 32'd0, 32'd0, 32'h10, 32'h100);
        @(posedge clk); #1;
        check("reg_jal_tgt_q", branch_target_q, 32'h110);
        check("reg_jal_taken_q", {31'd0, branch_taken_q}, 32'd1);
        check("reg_jal_alu_q", alu_result_q, 32'h104);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_alu_q", alu_result_q, 32'd0);
        check("async_rst_tgt_q", branch_target_q, 32'd0);
        check("async_rst_taken_q", {31'd0, branch_taken_q}, 32'd0);
        check("comb_during_rst", alu_result, 32'h104);
        @(negedge clk);
        rst_n = 1'b1;
        drive(7'b0110011, 3'd0, 7'd0, 32'd7, 32'd4, 32'd0, 32'd0);
        check("pre_edge_q", alu_result_q, 32'd0);
        @(posedge clk); #1;
        check("add_q", alu_result_q, 32'd11);
        drive(7'b0110011, 3'd0, 7'b0000001, 32'd7, 32'd4, 32'd0, 32'd0);
        @(posedge clk); #1;
        check("cv_q", {31'd0, custom_valid_q}, 32'd1);

        // Randomized OP-IMM then OP
        for (int i = 0; i < 2000; i++) begin
            logic [6:0]  op;
            logic [2:0]  f3;
            logic [6:0]  f7;
            logic [31:0] a, b, im, pc;
            op = (i < 1000) ? 7'b0010011 : 7'b0110011;
            f3 = 3'($urandom_range(0, 7));
            f7 = f7_pool[$urandom_range(0, 3)];
            a  = $urandom;
            b  = $urandom;
            im = $urandom;
            pc = $urandom;
            if (i % 4 == 0) im = {{20{im[11]}}, im[11:0]};
            drive(op, f3, f7, a, b, im, pc);
            exp = model(op, f3, f7, a, b, im);
            check("rand_res", alu_result, exp[31:0]);
            check("rand_cv", {31'd0, custom_valid}, {31'd0, exp[32]});
            check("rand_taken", {31'd0, branch_taken}, 32'd0);
            check("rand_tgt", branch_target, pc + im);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
